// File: rtl/nf_ahb_pkg.sv
// Shared AHB-Lite encodings and the nf_ahb2core state constants.
// Also holds the size/alignment helper used at transfer accept.
package nf_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
    localparam logic [2:0] ST_ERR1 = 3'd4;
    localparam logic [2:0] ST_ERR2 = 3'd5;

    // Anything wider than a word has no legal alignment on a 32-bit core port.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 1'b0;
            HSIZE_HALF: return addr_lo[0];
            HSIZE_WORD: return |addr_lo;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nf_ahb2core.sv
// AHB-Lite slave bridging to a core-style req/req_ack memory handshake.
// Optional REQ timeout enabled by defining NF_AHB2CORE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer pending, zero-wait OKAY
// DATA  | data phase of accepted transfer, capture hwdata_s
// REQ   | req held to the core target until req_ack
// RESP  | OKAY completion, may accept the next transfer
// ERR1  | first ERROR cycle (hready_s low)
// ERR2  | second ERROR cycle (hready_s high), may accept
module nf_ahb2core
    import nf_ahb_pkg::*;
#(
    parameter int unsigned timeout_c = 255
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr_s,
    input  logic [31:0] hwdata_s,
    output logic [31:0] hrdata_s,
    input  logic        hwrite_s,
    input  logic [1:0]  htrans_s,
    input  logic [2:0]  hsize_s,
    input  logic [2:0]  hburst_s,
    output logic [1:0]  hresp_s,
    output logic        hready_s,
    input  logic        hsel_s,
    output logic [31:0] addr,
    input  logic [31:0] rd,
    output logic [31:0] wd,
    output logic        we,
    output logic        req,
    input  logic        req_ack
);

    logic [2:0] state;
    logic       write_q;
    logic [2:0] size_q;
    logic       accept;
    logic       unused_inputs;

    assign hready_s = (state == ST_IDLE) || (state == ST_RESP) || (state == ST_ERR2);
    assign hresp_s  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign accept   = hsel_s && htrans_s[1] && hready_s;

    // Bursts are handled beat by beat; size only matters for the accept-time check.
    assign unused_inputs = ^{hburst_s, size_q, 16'(timeout_c)};

`ifdef NF_AHB2CORE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(timeout_c - 1);
    logic [15:0] tmo_cnt;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            hrdata_s <= '0;
            addr     <= '0;
            wd       <= '0;
            we       <= 1'b0;
            req      <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
`ifdef NF_AHB2CORE_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_DATA: begin
                    if (write_q) begin
                        wd <= hwdata_s;
                    end
                    req     <= 1'b1;
                    we      <= write_q;
                    state   <= ST_REQ;
`ifdef NF_AHB2CORE_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_REQ: begin
                    // An ack on the expiry cycle still completes normally.
                    if (req_ack) begin
                        if (!write_q) begin
                            hrdata_s <= rd;
                        end
                        req   <= 1'b0;
                        we    <= 1'b0;
                        state <= ST_RESP;
                    end
`ifdef NF_AHB2CORE_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        req   <= 1'b0;
                        we    <= 1'b0;
                        state <= ST_ERR1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    // IDLE, RESP and ERR2 are the cycles that can take a new address phase.
                    if (accept) begin
                        addr    <= haddr_s;
                        write_q <= hwrite_s;
                        size_q  <= hsize_s;
                        state   <= is_misaligned(hsize_s, haddr_s[1:0]) ? ST_ERR1 : ST_DATA;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
